cla_seq_adder: RTL
==================

Name: cla_seq_adder

Overview:
Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing one four_bit_cla instance, one nibble per clock, LSB nibble first. It registers the carry between nibbles and accumulates the result nibbles. It has a valid/ready request side and a valid/ready result side. It is the multi-word arithmetic front-end of the ALU datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥4 (elaboration error otherwise)
NIBBLES, WIDTH/4, derived local parameter: number of CLA passes per operation

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start_valid  in  1  request valid
start_ready  out  1  request accepted when start_valid && start_ready at clk edge
a  in  WIDTH  operand A, sampled at accept
b  in  WIDTH  operand B, sampled at accept
cin  in  1  carry-in (add) / borrow-in (sub), sampled at accept
sub  in  1  1 = subtract, sampled at accept
res_valid  out  1  result valid
res_ready  in  1  result consumed when res_valid && res_ready at clk edge
sum  out  WIDTH  result, registered
cout  out  1  carry out of MSB nibble, registered
overflow  out  1  two's-complement overflow, registered
zero  out  1  sum == 0, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n sampled only on clk rising edge).
- Reset values: state=IDLE, start_ready=1, res_valid=0, sum=0, cout=0, overflow=0, zero=0, nibble counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On accept:
  - latch a_q=a and b_q = sub ? ~b : b;
  - carry register = cin ^ sub (sub with cin=0 gives a−b; sub with cin=1 gives a−b−1);
  - counter=0; go to RUN.
- RUN: start_ready=0, res_valid=0. Each cycle:
  - CLA inputs are a_q[4k+3:4k], b_q[4k+3:4k] and the carry register, with k = counter.
  - At the edge, the CLA S output is written into sum nibble k, the carry register takes the CLA Cout, and the counter increments.
  - On the edge where k = NIBBLES−1: cout takes the CLA Cout, overflow = (a_q[MSB]==b_q[MSB]) && (final sum[MSB]!=a_q[MSB]), zero = (final sum==0), and the FSM goes to DONE.
- Latency: res_valid rises exactly NIBBLES cycles after the accept edge (4 for WIDTH=16, 1 for WIDTH=4).
- DONE: res_valid=1, start_ready=0. sum/cout/overflow/zero hold stable while res_ready=0. On handshake go to IDLE; start_ready=1 on the following cycle. There is no same-cycle result-to-accept bypass.
- Visibility of sum: sum is updated nibble-wise during RUN. Consumers read sum only while res_valid=1. The previous result is not preserved once a new request is accepted.
- start_valid outside IDLE is ignored; operands are never re-sampled mid-operation.
- The CLA's G/P/C outputs are left unconnected.
- Reset asserted in any state, including mid-RUN or in DONE with res_ready low: next edge returns to reset values, and the in-flight operation is discarded with no res_valid.
- Counter width: $clog2(NIBBLES) bits, minimum 1. The counter never wraps during normal operation because the FSM leaves RUN at NIBBLES−1.

Decomposition:
- Package cla_seq_pkg:
  - state_t enum {IDLE, RUN, DONE};
  - localparam NIBBLE_W=4;
  - helper function for counter width.
- One sub-module: the existing four_bit_cla, instantiated once (u_cla). No other hierarchy.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with start_valid=1 -> start_ready=1, res_valid=0, sum=0x0000, cout=0, overflow=0, zero=0, and no accept.
2. Add (WIDTH=16): a=0x1234, b=0x1111, cin=0, sub=0 -> res_valid exactly 4 cycles after accept with sum=0x2345, cout=0, overflow=0, zero=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1, cout=0.
3. Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, overflow=0. Also a=0xFFFF, b=0x0000, cin=1 gives the same result.
4. Subtract:
   - a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0.
   - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, overflow=1, cout=1.
   - a=0x0009, b=0x0003, sub=1, cin=1 -> sum=0x0005.
5. Backpressure: hold res_ready=0 for 5 cycles after res_valid with start_valid=1 and new operands -> outputs stable, start_ready=0, no accept. Raise res_ready -> handshake, start_ready=1 next cycle, and the new request is accepted then.
6. Reset mid-operation: accept 0x1234+0x1111, drop rst_n after 2 RUN cycles -> IDLE next edge, res_valid never asserted, sum=0. A following request completes correctly.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
// Holds the FSM state encoding and the counter-width helper.
package cla_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIBBLE_W = 4;

    // A single-nibble datapath still needs a 1-bit counter.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/four_bit_cla.sv
// 4-bit carry-lookahead adder slice.
// Also exposes group generate/propagate and the internal carries.
module four_bit_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       g_o,
    output logic       p_o,
    output logic [3:0] c
);
    logic [3:0] g;
    logic [3:0] p;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign p_o  = &p;
    assign cout = g_o | (p_o & cin);
    assign s    = p ^ c;

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit add/subtract that reuses one 4-bit CLA, one nibble per clock,
// LSB nibble first, with valid/ready request and result handshakes.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(NIBBLES);

    generate
        if ((WIDTH < NIBBLE_W) || (WIDTH % NIBBLE_W != 0)) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [NIBBLE_W-1:0] cla_a, cla_b, cla_s;
    logic                cla_cout;
    logic [WIDTH-1:0]    sum_next;
    int                  nib_idx;

    always_comb begin
        nib_idx = int'(cnt_q);
        cla_a   = a_q[nib_idx*NIBBLE_W +: NIBBLE_W];
        cla_b   = b_q[nib_idx*NIBBLE_W +: NIBBLE_W];
    end

    four_bit_cla u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (carry_q),
        .s    (cla_s),
        .cout (cla_cout),
        .g_o  (),
        .p_o  (),
        .c    ()
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        // Result as it will look once the current nibble lands; flags on the
        // last pass are derived from this rather than the stale register.
        sum_next = sum_q;
        sum_next[nib_idx*NIBBLE_W +: NIBBLE_W] = cla_s;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_next;
                carry_d = cla_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                    cnt_d   = '0;
                    cout_d  = cla_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sum_next[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (sum_next == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;

endmodule
